// File: rtl/npc_sequencer.sv
// npc_sequencer: next-PC sequencer feeding the PC register.
// Holds the nPC register and computes the PC register's next value each cycle.
// It handles sequential flow, branches and jumps, stall, and control-transfer
// error reporting.
//
// Optional feature macro: NPC_SEQ_DELAY_SLOT_EN
//   defined   -> delayed branches with a one-instruction delay slot, annul support
//                and a sticky delay-slot CTI error flag.
//   undefined -> redirects take effect combinationally and the wrong-path fetch
//                is squashed. There is no delay slot.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   pc_out                current PC from the PC register
//   stall                 hold PC and nPC this cycle
//   branch_taken/annul    resolved branch and its annul bit
//   branch_target         branch target address
//   jump, jump_target     unconditional jump and its target
//   pc_in                 next value for the PC register (combinational)
//   npc_out               current nPC (registered)
//   in_delay_slot         instruction at pc_out is a delay slot (registered)
//   squash_if             IF/ID loads a bubble on this edge (combinational)
//   cti_err               sticky: control transfer attempted inside a delay slot
module npc_sequencer #(
    parameter logic [31:0] RESET_NPC = 32'h0000_0004,
    parameter int unsigned INC       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_out,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic        branch_annul,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc_in,
    output logic [31:0] npc_out,
    output logic        in_delay_slot,
    output logic        squash_if,
    output logic        cti_err
);

    localparam int unsigned AW = 32;

    typedef enum logic {
        SEQ   = 1'b0,
        DSLOT = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] npc_q, npc_d;
    logic          err_q, err_d;

    logic          redirect_c;
    logic [AW-1:0] target_c;
    logic [AW-1:0] npc_inc_c;

    // Redirect decision and word-aligned target; jump wins over branch.
    always_comb begin
        redirect_c = (jump | branch_taken) & ~stall;
        target_c   = jump ? jump_target : branch_target;
        target_c   = {target_c[AW-1:2], 2'b00};
        npc_inc_c  = npc_q + AW'(INC);
    end

`ifndef NPC_SEQ_DELAY_SLOT_EN
    // The annul bit has no meaning without a delay slot.
    logic unused_annul_c;
    assign unused_annul_c = branch_annul;
`endif

    // Next-state, next-nPC and combinational outputs.
    always_comb begin
        state_d   = state_q;
        npc_d     = npc_q;
        err_d     = err_q;
        pc_in     = npc_q;
        squash_if = 1'b0;

        if (stall) begin
            pc_in = pc_out;
        end else begin
`ifdef NPC_SEQ_DELAY_SLOT_EN
            unique case (state_q)
                SEQ: begin
                    squash_if = branch_annul & ~branch_taken & ~jump;
                    if (redirect_c) begin
                        npc_d   = target_c;
                        state_d = DSLOT;
                    end else begin
                        npc_d   = npc_inc_c;
                    end
                end
                DSLOT: begin
                    // A CTI in the delay slot is dropped and flagged.
                    npc_d   = npc_inc_c;
                    state_d = SEQ;
                    if (redirect_c) begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    npc_d   = npc_inc_c;
                    state_d = SEQ;
                end
            endcase
`else
            state_d = SEQ;
            if (redirect_c) begin
                pc_in     = target_c;
                npc_d     = target_c + AW'(INC);
                squash_if = 1'b1;
            end else begin
                npc_d     = npc_inc_c;
            end
`endif
        end
    end

    // State, nPC and error registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEQ;
            npc_q   <= RESET_NPC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            err_q   <= err_d;
        end
    end

    assign npc_out       = npc_q;
    assign in_delay_slot = (state_q == DSLOT);
    assign cti_err       = err_q;

endmodule

// File: tb/tb_npc_sequencer.sv
module tb_npc_sequencer;

`ifdef NPC_SEQ_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic        stall;
    logic        branch_taken;
    logic        branch_annul;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_in;
    logic [31:0] npc_out;
    logic        in_delay_slot;
    logic        squash_if;
    logic        cti_err;

    int n_vec;
    int n_err;

    typedef struct {
        logic [31:0] pc_in;
        logic [31:0] npc;
        logic        ids;
        logic        sq;
        logic        err;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    npc_sequencer #(
        .RESET_NPC(32'h0000_0004),
        .INC      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_out       (pc_out),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_annul (branch_annul),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc_in        (pc_in),
        .npc_out      (npc_out),
        .in_delay_slot(in_delay_slot),
        .squash_if    (squash_if),
        .cti_err      (cti_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: loads pc_in every edge, resets to 0.
    always @(posedge clk or posedge reset) begin
        if (reset) pc_out <= 32'h0;
        else       pc_out <= pc_in;
    end

    task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cmp1(input string tag, input logic obs, input logic expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Push the expected outputs for the inputs just driven, then pop and compare.
    task automatic ex(input string tag, input logic [31:0] p, input logic [31:0] n,
                      input logic i, input logic s, input logic e);
        exp_t x;
        x.pc_in = p; x.npc = n; x.ids = i; x.sq = s; x.err = e;
        sb_q.push_back(x);
        tag_q.push_back(tag);
        #1;
        while (sb_q.size() > 0) begin
            exp_t  y;
            string t;
            y = sb_q.pop_front();
            t = tag_q.pop_front();
            cmp32({t, ".pc_in"}, pc_in, y.pc_in);
            cmp32({t, ".npc_out"}, npc_out, y.npc);
            cmp1({t, ".in_delay_slot"}, in_delay_slot, y.ids);
            cmp1({t, ".squash_if"}, squash_if, y.sq);
            cmp1({t, ".cti_err"}, cti_err, y.err);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_annul = 1'b0;
        branch_target = 32'h0;
        jump = 1'b0;
        jump_target = 32'h0;

        // Reset state
        @(negedge clk);
        ex("reset", 32'h4, 32'h4, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Sequential flow
        @(negedge clk);
        ex("seq1", 32'h8, 32'h8, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ex("seq2", 32'hC, 32'hC, 1'b0, 1'b0, 1'b0);

        // Branch to 0x103 (aligned to 0x100) with pc_out=8, npc=12
        branch_taken = 1'b1;
        branch_target = 32'h103;
        ex("br_req", DS ? 32'hC : 32'h100, 32'hC, 1'b0, !DS, 1'b0);
        @(negedge clk);
        branch_taken = 1'b0;
        if (DS) begin
            ex("br_e1", 32'h100, 32'h100, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        ex("br_e2", 32'h104, 32'h104, 1'b0, 1'b0, 1'b0);

        // Stall with a pending jump: pc_in mirrors pc_out, nPC frozen
        stall = 1'b1;
        jump = 1'b1;
        jump_target = 32'h200;
        ex("stall0", 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ex("stall1", 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ex("stall2", 32'h100, 32'h104, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        ex("unstall", DS ? 32'h104 : 32'h200, 32'h104, 1'b0, !DS, 1'b0);
        @(negedge clk);
        if (DS) begin
            // Jump in the delay slot: ignored, flagged
            jump_target = 32'h300;
            ex("ds_cti", 32'h200, 32'h200, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
        end
        jump = 1'b0;
        ex("jmp_done", 32'h204, 32'h204, 1'b0, 1'b0, DS);

        // Annul with branch not taken
        branch_annul = 1'b1;
        ex("annul", 32'h204, 32'h204, 1'b0, DS, DS);
        @(negedge clk);
        branch_annul = 1'b0;
        ex("annul_after", 32'h208, 32'h208, 1'b0, 1'b0, DS);

        // Branch to 0x100, then reset in the middle of the following cycle
        branch_taken = 1'b1;
        branch_target = 32'h100;
        ex("br2_req", DS ? 32'h208 : 32'h100, 32'h208, 1'b0, !DS, DS);
        @(negedge clk);
        branch_taken = 1'b0;
        if (DS) ex("br2_dslot", 32'h100, 32'h100, 1'b1, 1'b0, 1'b1);
        else    ex("br2_dslot", 32'h104, 32'h104, 1'b0, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        ex("mid_reset", 32'h4, 32'h4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        ex("post_reset", 32'h4, 32'h4, 1'b0, 1'b0, 1'b0);

        // Wrap: jump and branch together, jump wins; nPC reaches FFFF_FFFC then 0
        jump = 1'b1;
        jump_target = DS ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
        branch_taken = 1'b1;
        branch_target = 32'h40;
        ex("wrap_req", DS ? 32'h4 : 32'hFFFF_FFF8, 32'h4, 1'b0, !DS, 1'b0);
        @(negedge clk);
        jump = 1'b0;
        branch_taken = 1'b0;
        ex("wrap_top", 32'hFFFF_FFFC, 32'hFFFF_FFFC, DS, 1'b0, 1'b0);
        @(negedge clk);
        ex("wrap_zero", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/npc_sequencer.md
# npc_sequencer

Next-PC sequencer directly upstream of the PC register. Holds the nPC register and computes the PC register's input each cycle. Supports sequential flow, taken branches and jumps with a one-instruction delay slot, optional delay-slot annulment, and pipeline stall. Reports delay-slot status and control-transfer errors to the decode/hazard logic.

## Interface
Parameters:
- RESET_NPC, 32'h0000_0004, nPC value after reset (PC register resets to 0)
- INC, 4, sequential increment in bytes

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pc_out  in  32  current PC from the PC register
- stall  in  1  hold PC and nPC this cycle
- branch_taken  in  1  conditional branch resolved taken (valid only when !stall)
- branch_annul  in  1  annul bit of the current branch instruction
- branch_target  in  32  branch target address
- jump  in  1  unconditional jump
- jump_target  in  32  jump target address
- pc_in  out  32  next value for the PC register
- npc_out  out  32  current nPC
- in_delay_slot  out  1  instruction at pc_out is a delay slot
- squash_if  out  1  IF/ID must load a bubble on this edge
- cti_err  out  1  sticky: control transfer attempted inside a delay slot

## Operation
- Registers: npc_q (32), state {SEQ, DSLOT}, err_q.
- Reset (async): npc_q = RESET_NPC, state = SEQ, err_q = 0. Outputs at reset: pc_in = RESET_NPC, npc_out = RESET_NPC, in_delay_slot = 0, squash_if = 0, cti_err = 0.
- redirect = (jump | branch_taken) & !stall. Target = jump ? jump_target : branch_target (jump wins when both are asserted). Bits [1:0] of the target are forced to 00.
- Stall: pc_in = pc_out. npc_q, state and err_q hold. jump, branch_taken and branch_annul are ignored, and the requester holds them until stall drops.
- SEQ, no redirect: pc_in = npc_q; npc_q <= npc_q + INC; stay in SEQ.
- SEQ, redirect: pc_in = npc_q (the delay slot); npc_q <= target; go to DSLOT.
- DSLOT: pc_in = npc_q; npc_q <= npc_q + INC; go to SEQ.
- Redirect while in DSLOT: the redirect is ignored and the sequential update is applied. err_q <= 1, sticky until reset.
- Annul: in SEQ, when branch_annul & !branch_taken & !jump & !stall, squash_if = 1. The delay-slot instruction becomes a bubble; PC still advances sequentially.
- Arithmetic: all +INC is modulo 2^32, so 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- pc_in is combinational from npc_q, pc_out and stall only; there is no path from the redirect inputs to pc_in.
- squash_if and the redirect decision are combinational, sampled at the clock edge.
- in_delay_slot = (state == DSLOT) and is registered.
- A redirect in cycle N reaches the PC register two edges later (N+2), after one delay-slot instruction.
- A reset asserted mid-DSLOT returns the block immediately to SEQ with npc_q = RESET_NPC, and the pending target is discarded.

## Configuration
- Macro: NPC_SEQ_DELAY_SLOT_EN.
- Defined: delayed-branch behaviour as described above.
- Undefined:
  - On redirect, pc_in = target combinationally and npc_q <= target + INC.
  - squash_if = redirect, so the wrong-path fetch is flushed.
  - state stays SEQ, in_delay_slot = 0, cti_err = 0, and branch_annul is ignored.

## Test plan
- Reset, then 3 edges with no events: pc_in 4 → 8 → 12 → 16; npc_out tracks pc_in. in_delay_slot, squash_if and cti_err all 0.
- Branch: with pc_out = 8 and npc = 12, pulse branch_taken with target 0x103:
  - edge 1: pc_in was 12, npc becomes 0x100, in_delay_slot = 1
  - edge 2: pc_in was 0x100, npc becomes 0x104, in_delay_slot = 0
  - Without the macro: pc_in = 0x100 in the same cycle, squash_if = 1, npc becomes 0x104.
- Stall: hold stall for 3 cycles with jump = 1 and target 0x200. pc_in = pc_out and npc is frozen throughout. After stall drops, the jump is taken on the first edge.
- Annul: in SEQ, branch_annul = 1 with branch_taken = 0. squash_if = 1 for exactly that cycle and npc advances by 4.
- Delay-slot error: in DSLOT with npc = 0x100, assert jump to 0x300. npc becomes 0x104 and cti_err = 1, which stays set until reset.
- Reset mid-flight: assert reset while in DSLOT with npc = 0x100. Immediately npc = 4, state = SEQ, cti_err = 0.
- Wrap: with npc = 0xFFFF_FFFC, one edge gives npc = 0.
